// File: rtl/dvi_generator.sv
// dvi_generator: fixed 640x480@60 Hz video timing (800x525 total) plus
// three TMDS channel encoders. Counters feed the pixel source directly;
// sync/de are delayed one clock to line up with the registered rgb_data,
// and the encoders add a second register stage.

module tmds_channel #(
   parameter logic [9:0] RESET_SYM = 10'b1101010100
) (
   input  logic       clk_pixel,
   input  logic       n_reset,
   input  logic [7:0] data,
   input  logic       de,
   input  logic [1:0] ctrl,
   output logic [9:0] tmds
);

   logic [3:0]        n1_d;
   logic              use_xnor;
   logic [8:0]        q_m;
   logic [3:0]        n1_q;
   logic signed [5:0] bal;        // ones minus zeros of q_m[7:0]
   logic signed [5:0] disp;       // running disparity
   logic signed [5:0] disp_next;
   logic [9:0]        sym;
   logic [9:0]        token;

   // Transition minimisation followed by the DC-balance decision
   always_comb begin
      n1_d = '0;
      for (int unsigned i = 0; i < 8; i++) n1_d = n1_d + 4'(data[i]);
      use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !data[0]);
      q_m    = '0;
      q_m[0] = data[0];
      for (int unsigned i = 1; i < 8; i++)
         q_m[i] = use_xnor ? ~(q_m[i-1] ^ data[i]) : (q_m[i-1] ^ data[i]);
      q_m[8] = !use_xnor;
      n1_q = '0;
      for (int unsigned i = 0; i < 8; i++) n1_q = n1_q + 4'(q_m[i]);
      bal = $signed({1'b0, n1_q, 1'b0}) - 6'sd8;
      if ((disp == 0) || (bal == 0)) begin
         sym       = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
         disp_next = q_m[8] ? (disp + bal) : (disp - bal);
      end else if (((disp > 0) && (bal > 0)) || ((disp < 0) && (bal < 0))) begin
         sym       = {1'b1, q_m[8], ~q_m[7:0]};
         disp_next = disp - bal + (q_m[8] ? 6'sd2 : 6'sd0);
      end else begin
         sym       = {1'b0, q_m[8], q_m[7:0]};
         disp_next = disp + bal - (q_m[8] ? 6'sd0 : 6'sd2);
      end
   end

   // Control token lookup for blanking periods
   always_comb begin
      case (ctrl)
         2'b00:   token = 10'b1101010100;
         2'b01:   token = 10'b0010101011;
         2'b10:   token = 10'b0101010100;
         default: token = 10'b1010101011;
      endcase
   end

   // Output symbol register; disparity is cleared during blanking
   always_ff @(posedge clk_pixel or negedge n_reset) begin
      if (!n_reset) begin
         tmds <= RESET_SYM;
         disp <= '0;
      end else if (de) begin
         tmds <= sym;
         disp <= disp_next;
      end else begin
         tmds <= token;
         disp <= '0;
      end
   end

endmodule

module dvi_generator #(
   parameter int unsigned START_X = 0,
   parameter int unsigned START_Y = 0
) (
   input  logic        clk_pixel,
   input  logic        n_reset,
   input  logic [23:0] rgb_data,
   output logic [9:0]  tmds_r,
   output logic [9:0]  tmds_g,
   output logic [9:0]  tmds_b,
   output logic [9:0]  xpos,
   output logic [9:0]  ypos,
   output logic        line_end,
   output logic        frame_end
);

   logic de;
   logic hsync;
   logic vsync;
   logic de_d;
   logic hsync_d;
   logic vsync_d;

   assign line_end  = (xpos == 10'd799);
   assign frame_end = line_end && (ypos == 10'd524);

   // Timing decode of the current counter position (syncs active-low)
   always_comb begin
      de    = (xpos < 10'd640) && (ypos < 10'd480);
      hsync = !((xpos >= 10'd656) && (xpos <= 10'd751));
      vsync = !((ypos >= 10'd490) && (ypos <= 10'd491));
   end

   // Free-running position counters
   always_ff @(posedge clk_pixel or negedge n_reset) begin
      if (!n_reset) begin
         xpos <= 10'(START_X);
         ypos <= 10'(START_Y);
      end else if (line_end) begin
         xpos <= '0;
         ypos <= (ypos == 10'd524) ? '0 : ypos + 10'd1;
      end else begin
         xpos <= xpos + 10'd1;
      end
   end

   // Delay de/sync one clock to match the source's registered rgb_data
   always_ff @(posedge clk_pixel or negedge n_reset) begin
      if (!n_reset) begin
         de_d    <= 1'b0;
         hsync_d <= 1'b1;
         vsync_d <= 1'b1;
      end else begin
         de_d    <= de;
         hsync_d <= hsync;
         vsync_d <= vsync;
      end
   end

   tmds_channel #(.RESET_SYM(10'b1101010100)) u_chan_r (
      .clk_pixel (clk_pixel),
      .n_reset   (n_reset),
      .data      (rgb_data[23:16]),
      .de        (de_d),
      .ctrl      (2'b00),
      .tmds      (tmds_r)
   );

   tmds_channel #(.RESET_SYM(10'b1101010100)) u_chan_g (
      .clk_pixel (clk_pixel),
      .n_reset   (n_reset),
      .data      (rgb_data[15:8]),
      .de        (de_d),
      .ctrl      (2'b00),
      .tmds      (tmds_g)
   );

   tmds_channel #(.RESET_SYM(10'b1010101011)) u_chan_b (
      .clk_pixel (clk_pixel),
      .n_reset   (n_reset),
      .data      (rgb_data[7:0]),
      .de        (de_d),
      .ctrl      ({vsync_d, hsync_d}),
      .tmds      (tmds_b)
   );

endmodule

// File: tb/tb_dvi_generator.sv
// Bench for dvi_generator: three instances (default start, start near the
// vertical sync lines, start just before frame end) checked every cycle
// against an arithmetic timing model and a reference TMDS encoder.

module tb_dvi_generator;

   localparam int FRAME = 800 * 525;

   logic             clk_pixel = 1'b0;
   logic [2:0]       rst_n     = 3'b000;
   logic [23:0]      rgb_data  = '0;
   logic [2:0][9:0]  t_r, t_g, t_b, xp, yp;
   logic [2:0]       le, fe;

   int compared   = 0;
   int mismatched = 0;

   int          base   [3];
   int          kcnt   [3];
   int          disp   [3][3];
   logic [9:0]  ex_x   [3];
   logic [9:0]  ex_y   [3];
   logic [9:0]  ex_sym [3][3];   // channel index 0 = blue, 1 = green, 2 = red

   always #20 clk_pixel = ~clk_pixel;

   dvi_generator dut_a (
      .clk_pixel (clk_pixel), .n_reset (rst_n[0]), .rgb_data (rgb_data),
      .tmds_r (t_r[0]), .tmds_g (t_g[0]), .tmds_b (t_b[0]),
      .xpos (xp[0]), .ypos (yp[0]), .line_end (le[0]), .frame_end (fe[0])
   );

   dvi_generator #(.START_X(0), .START_Y(486)) dut_b (
      .clk_pixel (clk_pixel), .n_reset (rst_n[1]), .rgb_data (rgb_data),
      .tmds_r (t_r[1]), .tmds_g (t_g[1]), .tmds_b (t_b[1]),
      .xpos (xp[1]), .ypos (yp[1]), .line_end (le[1]), .frame_end (fe[1])
   );

   dvi_generator #(.START_X(795), .START_Y(524)) dut_c (
      .clk_pixel (clk_pixel), .n_reset (rst_n[2]), .rgb_data (rgb_data),
      .tmds_r (t_r[2]), .tmds_g (t_g[2]), .tmds_b (t_b[2]),
      .xpos (xp[2]), .ypos (yp[2]), .line_end (le[2]), .frame_end (fe[2])
   );

   function automatic logic [9:0] ctl_tok(input logic c1, input logic c0);
      case ({c1, c0})
         2'b00:   return 10'b1101010100;
         2'b01:   return 10'b0010101011;
         2'b10:   return 10'b0101010100;
         default: return 10'b1010101011;
      endcase
   endfunction

   // Reference DVI 1.0 encoder using integer counts
   function automatic logic [9:0] tmds_ref(input logic [7:0] d, input int cnt, output int cnt_o);
      logic [8:0] qm;
      bit xn;
      int ones, bal;
      xn = ($countones(d) > 4) || (($countones(d) == 4) && (d[0] == 1'b0));
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = !xn;
      ones = $countones(qm[7:0]);
      bal  = ones - (8 - ones);
      if (cnt == 0 || bal == 0) begin
         cnt_o = qm[8] ? cnt + bal : cnt - bal;
         return {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      end else if ((cnt > 0 && bal > 0) || (cnt < 0 && bal < 0)) begin
         cnt_o = cnt + 2 * int'(qm[8]) - bal;
         return {1'b1, qm[8], ~qm[7:0]};
      end else begin
         cnt_o = cnt - 2 * int'(!qm[8]) + bal;
         return {1'b0, qm[8], qm[7:0]};
      end
   endfunction

   function automatic void decode_pos(input int p, output int x, output int y,
                                      output bit de, output bit hs, output bit vs);
      x  = p % 800;
      y  = p / 800;
      de = (x < 640) && (y < 480);
      hs = !(x >= 656 && x <= 751);
      vs = !(y >= 490 && y <= 491);
   endfunction

   function automatic logic [23:0] pix_f(input int x, input int y);
      logic [9:0] xv, yv;
      xv = 10'(x);
      yv = 10'(y);
      return {xv[7:0] ^ 8'hA5, xv[9:2] ^ 8'h3C, yv[7:0] ^ 8'h96};
   endfunction

   // Advance one clock and update the model's expectations for every instance
   task automatic step();
      logic [23:0] held;
      int x, y, nd;
      bit de, hs, vs;
      held = rgb_data;
      @(posedge clk_pixel);
      #1;
      for (int d = 0; d < 3; d++) begin
         if (!rst_n[d]) begin
            kcnt[d] = 0;
            ex_x[d] = 10'(base[d] % 800);
            ex_y[d] = 10'(base[d] / 800);
            ex_sym[d][0] = ctl_tok(1'b1, 1'b1);
            ex_sym[d][1] = ctl_tok(1'b0, 1'b0);
            ex_sym[d][2] = ctl_tok(1'b0, 1'b0);
            for (int ch = 0; ch < 3; ch++) disp[d][ch] = 0;
         end else begin
            kcnt[d]++;
            decode_pos((base[d] + kcnt[d]) % FRAME, x, y, de, hs, vs);
            ex_x[d] = 10'(x);
            ex_y[d] = 10'(y);
            if (kcnt[d] == 1) begin
               ex_sym[d][0] = ctl_tok(1'b1, 1'b1);
               ex_sym[d][1] = ctl_tok(1'b0, 1'b0);
               ex_sym[d][2] = ctl_tok(1'b0, 1'b0);
            end else begin
               decode_pos((base[d] + kcnt[d] - 2) % FRAME, x, y, de, hs, vs);
               if (de) begin
                  for (int ch = 0; ch < 3; ch++) begin
                     ex_sym[d][ch] = tmds_ref(held[8*ch +: 8], disp[d][ch], nd);
                     disp[d][ch] = nd;
                  end
               end else begin
                  ex_sym[d][0] = ctl_tok(vs, hs);
                  ex_sym[d][1] = ctl_tok(1'b0, 1'b0);
                  ex_sym[d][2] = ctl_tok(1'b0, 1'b0);
                  for (int ch = 0; ch < 3; ch++) disp[d][ch] = 0;
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 3'b000;
      step();
      step();
      compared += 6;
      if (xp[0] !== 10'd0) begin mismatched++; $display("FAIL reset_xpos got=%0d exp=0", xp[0]); end
      if (yp[0] !== 10'd0) begin mismatched++; $display("FAIL reset_ypos got=%0d exp=0", yp[0]); end
      if (t_r[0] !== 10'b1101010100) begin mismatched++; $display("FAIL reset_tmds_r got=%b exp=1101010100", t_r[0]); end
      if (t_g[0] !== 10'b1101010100) begin mismatched++; $display("FAIL reset_tmds_g got=%b exp=1101010100", t_g[0]); end
      if (t_b[0] !== 10'b1010101011) begin mismatched++; $display("FAIL reset_tmds_b got=%b exp=1010101011", t_b[0]); end
      if (yp[1] !== 10'd486) begin mismatched++; $display("FAIL reset_start_y got=%0d exp=486", yp[1]); end
      rst_n[0] = 1'b1;
   endtask

   task automatic test_counters();
      int le_count = 0;
      for (int i = 0; i < 900; i++) begin
         step();
         rgb_data = 24'($urandom);
         compared += 4;
         if (xp[0] !== ex_x[0]) begin mismatched++; $display("FAIL cnt_xpos cyc=%0d got=%0d exp=%0d", i, xp[0], ex_x[0]); end
         if (yp[0] !== ex_y[0]) begin mismatched++; $display("FAIL cnt_ypos cyc=%0d got=%0d exp=%0d", i, yp[0], ex_y[0]); end
         if (le[0] !== (ex_x[0] == 10'd799)) begin mismatched++; $display("FAIL cnt_line_end cyc=%0d got=%b x=%0d", i, le[0], ex_x[0]); end
         if (fe[0] !== (ex_x[0] == 10'd799 && ex_y[0] == 10'd524)) begin mismatched++; $display("FAIL cnt_frame_end cyc=%0d got=%b", i, fe[0]); end
         if (le[0] === 1'b1) le_count++;
      end
      compared++;
      if (le_count != 1) begin mismatched++; $display("FAIL cnt_line_pulses got=%0d exp=1", le_count); end
   endtask

   // mode 0: random rgb, mode 1: constant 0, mode 2: constant all-ones
   task automatic test_pixels(input string name, input int mode, input int ncyc);
      for (int i = 0; i < ncyc; i++) begin
         rgb_data = (mode == 0) ? 24'($urandom) : (mode == 1) ? 24'h000000 : 24'hFFFFFF;
         step();
         compared += 3;
         if (t_r[0] !== ex_sym[0][2]) begin mismatched++; $display("FAIL %s_r cyc=%0d got=%b exp=%b", name, i, t_r[0], ex_sym[0][2]); end
         if (t_g[0] !== ex_sym[0][1]) begin mismatched++; $display("FAIL %s_g cyc=%0d got=%b exp=%b", name, i, t_g[0], ex_sym[0][1]); end
         if (t_b[0] !== ex_sym[0][0]) begin mismatched++; $display("FAIL %s_b cyc=%0d got=%b exp=%b", name, i, t_b[0], ex_sym[0][0]); end
      end
   endtask

   task automatic test_latency();
      int x, y, q, nd;
      bit de, hs, vs;
      logic [9:0] e_r, e_g, e_b;
      e_r = tmds_ref(8'hA5, 0, nd);
      e_g = tmds_ref(8'h3C, 0, nd);
      e_b = tmds_ref(8'h96, 0, nd);
      rst_n[0] = 1'b0;
      step();
      rst_n[0] = 1'b1;
      rgb_data = 24'($urandom);
      while (kcnt[0] < 650) begin
         step();
         decode_pos((kcnt[0] - 1) % FRAME, x, y, de, hs, vs);
         rgb_data = pix_f(x, y);
         if (kcnt[0] >= 2) begin
            q = kcnt[0] - 2;
            if (q == 0) begin
               compared += 3;
               if (t_r[0] !== e_r) begin mismatched++; $display("FAIL lat_pix00_r got=%b exp=%b", t_r[0], e_r); end
               if (t_g[0] !== e_g) begin mismatched++; $display("FAIL lat_pix00_g got=%b exp=%b", t_g[0], e_g); end
               if (t_b[0] !== e_b) begin mismatched++; $display("FAIL lat_pix00_b got=%b exp=%b", t_b[0], e_b); end
            end
            if (q == 640) begin
               compared += 2;
               if (t_r[0] !== 10'b1101010100) begin mismatched++; $display("FAIL lat_first_ctl_r got=%b exp=1101010100", t_r[0]); end
               if (t_b[0] !== 10'b1010101011) begin mismatched++; $display("FAIL lat_first_ctl_b got=%b exp=1010101011", t_b[0]); end
            end
            compared += 3;
            if (t_r[0] !== ex_sym[0][2]) begin mismatched++; $display("FAIL lat_r q=%0d got=%b exp=%b", q, t_r[0], ex_sym[0][2]); end
            if (t_g[0] !== ex_sym[0][1]) begin mismatched++; $display("FAIL lat_g q=%0d got=%b exp=%b", q, t_g[0], ex_sym[0][1]); end
            if (t_b[0] !== ex_sym[0][0]) begin mismatched++; $display("FAIL lat_b q=%0d got=%b exp=%b", q, t_b[0], ex_sym[0][0]); end
         end
      end
   endtask

   task automatic test_sync_tokens();
      int x, y, fe_count = 0;
      bit de, hs, vs, prev_fe = 0;
      logic [9:0] want_b;
      rst_n[1] = 1'b1;
      for (int i = 0; i < 32200; i++) begin
         rgb_data = 24'($urandom);
         step();
         compared += 7;
         if (xp[1] !== ex_x[1]) begin mismatched++; $display("FAIL frm_xpos cyc=%0d got=%0d exp=%0d", i, xp[1], ex_x[1]); end
         if (yp[1] !== ex_y[1]) begin mismatched++; $display("FAIL frm_ypos cyc=%0d got=%0d exp=%0d", i, yp[1], ex_y[1]); end
         if (le[1] !== (ex_x[1] == 10'd799)) begin mismatched++; $display("FAIL frm_line_end cyc=%0d got=%b", i, le[1]); end
         if (fe[1] !== (ex_x[1] == 10'd799 && ex_y[1] == 10'd524)) begin mismatched++; $display("FAIL frm_frame_end cyc=%0d got=%b", i, fe[1]); end
         if (t_r[1] !== ex_sym[1][2]) begin mismatched++; $display("FAIL frm_r cyc=%0d got=%b exp=%b", i, t_r[1], ex_sym[1][2]); end
         if (t_g[1] !== ex_sym[1][1]) begin mismatched++; $display("FAIL frm_g cyc=%0d got=%b exp=%b", i, t_g[1], ex_sym[1][1]); end
         if (t_b[1] !== ex_sym[1][0]) begin mismatched++; $display("FAIL frm_b cyc=%0d got=%b exp=%b", i, t_b[1], ex_sym[1][0]); end
         if (kcnt[1] >= 2) begin
            decode_pos((base[1] + kcnt[1] - 2) % FRAME, x, y, de, hs, vs);
            if (!de) begin
               if (!hs && !vs)     want_b = 10'b1101010100;
               else if (!hs)       want_b = 10'b0101010100;
               else if (!vs)       want_b = 10'b0010101011;
               else                want_b = 10'b1010101011;
               compared += 2;
               if (t_b[1] !== want_b) begin mismatched++; $display("FAIL sync_tok_b x=%0d y=%0d got=%b exp=%b", x, y, t_b[1], want_b); end
               if (t_r[1] !== 10'b1101010100 || t_g[1] !== 10'b1101010100) begin
                  mismatched++; $display("FAIL blank_tok_rg x=%0d y=%0d got=%b/%b exp=1101010100", x, y, t_r[1], t_g[1]);
               end
            end
         end
         if (prev_fe) begin
            compared++;
            if (xp[1] !== 10'd0 || yp[1] !== 10'd0) begin mismatched++; $display("FAIL frm_wrap got=%0d,%0d exp=0,0", xp[1], yp[1]); end
         end
         prev_fe = (fe[1] === 1'b1);
         if (prev_fe) fe_count++;
      end
      compared++;
      if (fe_count != 1) begin mismatched++; $display("FAIL frm_pulses got=%0d exp=1", fe_count); end
   endtask

   task automatic test_mid_reset();
      rst_n[2] = 1'b1;
      step();
      step();
      compared++;
      if (xp[2] !== 10'd797) begin mismatched++; $display("FAIL mid_pre_xpos got=%0d exp=797", xp[2]); end
      rst_n[2] = 1'b0;
      #1;
      compared += 3;
      if (xp[2] !== 10'd795) begin mismatched++; $display("FAIL mid_async_xpos got=%0d exp=795", xp[2]); end
      if (yp[2] !== 10'd524) begin mismatched++; $display("FAIL mid_async_ypos got=%0d exp=524", yp[2]); end
      if (t_b[2] !== 10'b1010101011) begin mismatched++; $display("FAIL mid_async_tmds_b got=%b exp=1010101011", t_b[2]); end
      step();
      rst_n[2] = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step();
         compared += 3;
         if (fe[2] !== (i == 4)) begin mismatched++; $display("FAIL mid_frame_end clk=%0d got=%b exp=%b", i, fe[2], (i == 4)); end
         if (xp[2] !== ((i == 5) ? 10'd0 : 10'(795 + i))) begin mismatched++; $display("FAIL mid_xpos clk=%0d got=%0d", i, xp[2]); end
         if (yp[2] !== ((i == 5) ? 10'd0 : 10'd524)) begin mismatched++; $display("FAIL mid_ypos clk=%0d got=%0d", i, yp[2]); end
      end
   endtask

   initial begin
      base[0] = 0;
      base[1] = 486 * 800;
      base[2] = 524 * 800 + 795;
      for (int d = 0; d < 3; d++) kcnt[d] = 0;
      #5;
      test_reset();
      test_counters();
      test_pixels("pix_rand", 0, 1600);
      test_pixels("pix_zero", 1, 800);
      test_pixels("pix_ff", 2, 800);
      test_latency();
      test_sync_tokens();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
